// File: rtl/alu_issue_scoreboard_if.sv
// Decode-to-issue bundle: decoded ALU instruction fields
// plus the flush request, with the stall returned to decode.
interface alu_issue_scoreboard_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_wb;
  logic [2:0]       id_aluSig;
  logic             flush;
  logic             stall;

  modport master (
    output id_valid,
    output id_rs,
    output id_rt,
    output id_rd,
    output id_wb,
    output id_aluSig,
    output flush,
    input  stall
  );

  modport slave (
    input  id_valid,
    input  id_rs,
    input  id_rt,
    input  id_rd,
    input  id_wb,
    input  id_aluSig,
    input  flush,
    output stall
  );
endinterface

// File: rtl/alu_issue_scoreboard.sv
// In-order ALU issue with a shift-register write scoreboard.
// No forwarding: any RAW hazard stalls decode until retirement.
module alu_issue_scoreboard #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_scoreboard_if.slave id_if,
  output logic                  ex_valid,
  output logic [2:0]            ex_aluSig,
  output logic [REG_W-1:0]      ex_rd,
  output logic                  wb_valid,
  output logic [REG_W-1:0]      wb_rd,
  output logic [DEPTH-1:0]      busy,
  output logic [15:0]           stall_count
);

  typedef struct packed {
    logic             v;
    logic             wb;
    logic [REG_W-1:0] rd;
    logic [2:0]       alu;
  } ent_t;

  ent_t        ent_q [DEPTH];
  ent_t        ent_d [DEPTH];
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  logic hit;
  logic hazard;
  logic issue;
  logic stall;

  // Register 0 and non-writing entries are never a dependency.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].v && ent_q[i].wb &&
          (ent_q[i].rd != '0) &&
          ((ent_q[i].rd == id_if.id_rs) ||
           (ent_q[i].rd == id_if.id_rt))) begin
        hit = 1'b1;
      end
    end
  end

  assign hazard = id_if.id_valid & hit;
  assign issue  = id_if.id_valid & ~hit & ~id_if.flush;
  assign stall  = hazard & ~id_if.flush;

  assign id_if.stall = stall;

  // The pipe always advances; a stall only injects a bubble.
  always_comb begin
    ent_d[0] = '0;
    if (issue) begin
      ent_d[0].v   = 1'b1;
      ent_d[0].wb  = id_if.id_wb;
      ent_d[0].rd  = id_if.id_rd;
      ent_d[0].alu = id_if.id_aluSig;
    end
    for (int i = 1; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i-1];
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy[i] = ent_q[i].v & ent_q[i].wb;
    end
  end

  assign ex_valid    = ent_q[0].v;
  assign ex_aluSig   = ent_q[0].alu;
  assign ex_rd       = ent_q[0].rd;
  assign wb_valid    = ent_q[DEPTH-1].v & ent_q[DEPTH-1].wb;
  assign wb_rd       = ent_q[DEPTH-1].rd;
  assign stall_count = stall_count_q;

endmodule
